// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: condition codes, the ALU flag
// bundle, the BHT reset value and the saturating-arithmetic helpers.
package branch_resolve_unit_pkg;

  localparam logic [2:0] COND_NEVER  = 3'b000;
  localparam logic [2:0] COND_ALWAYS = 3'b001;
  localparam logic [2:0] COND_EQ     = 3'b010;
  localparam logic [2:0] COND_NE     = 3'b011;
  localparam logic [2:0] COND_LT     = 3'b100;
  localparam logic [2:0] COND_GE     = 3'b101;
  localparam logic [2:0] COND_LTU    = 3'b110;
  localparam logic [2:0] COND_GEU    = 3'b111;

  // Weakly not-taken: one taken resolution is enough to flip the prediction.
  localparam logic [1:0] WEAK_NT = 2'b01;

  // Counters wider than this are not supported by sat_inc.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input int unsigned     width);
    logic [SAT_W-1:0] max_v;
    max_v = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
    sat_inc = (val >= max_v) ? max_v : val + SAT_W'(1);
  endfunction

  // Two-bit saturating predictor update: up on taken, down on not-taken.
  function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic up);
    if (up) bht_next = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else    bht_next = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  // Branch condition evaluated against a flag set. LT/GE are the signed
  // compares (N xor V), LTU/GEU the unsigned ones (C = no borrow).
  function automatic logic eval_cond(input logic [2:0] cc, input alu_flags_t f);
    case (cc)
      COND_NEVER:  eval_cond = 1'b0;
      COND_ALWAYS: eval_cond = 1'b1;
      COND_EQ:     eval_cond = f.z;
      COND_NE:     eval_cond = ~f.z;
      COND_LT:     eval_cond = f.n ^ f.v;
      COND_GE:     eval_cond = ~(f.n ^ f.v);
      COND_LTU:    eval_cond = ~f.c;
      COND_GEU:    eval_cond = f.c;
      default:     eval_cond = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between the pipeline (master) and the branch resolve unit (slave).
//
// Handshake: there is no back-pressure. br_valid is a qualifier the unit always
// accepts on the rising edge where it is high; flag_we likewise captures the
// alu_* values on that edge. resolved/redirect/flush are one-cycle pulses that
// appear the cycle after acceptance; taken and redirect_pc are only meaningful
// while resolved (resp. redirect) is high and otherwise hold their last value.
interface branch_resolve_unit_if #(
  parameter int PC_WIDTH     = 8,
  parameter int OFFSET_WIDTH = 5,
  parameter int CNT_WIDTH    = 16
);
  logic                    flag_we;
  logic                    alu_zero;
  logic                    alu_neg;
  logic                    alu_carry;
  logic                    alu_ovf;
  logic                    br_valid;
  logic [2:0]              br_cond;
  logic [PC_WIDTH-1:0]     br_pc;
  logic [OFFSET_WIDTH-1:0] br_offset;
  logic                    br_pred_taken;
  logic [PC_WIDTH-1:0]     lookup_pc;
  logic                    pred_taken;
  logic                    taken;
  logic                    resolved;
  logic                    redirect;
  logic [PC_WIDTH-1:0]     redirect_pc;
  logic                    flush;
  logic [CNT_WIDTH-1:0]    br_count;
  logic [CNT_WIDTH-1:0]    mispred_count;

  modport master (
    output flag_we, alu_zero, alu_neg, alu_carry, alu_ovf,
    output br_valid, br_cond, br_pc, br_offset, br_pred_taken, lookup_pc,
    input  pred_taken, taken, resolved, redirect, redirect_pc, flush,
    input  br_count, mispred_count
  );

  modport slave (
    input  flag_we, alu_zero, alu_neg, alu_carry, alu_ovf,
    input  br_valid, br_cond, br_pc, br_offset, br_pred_taken, lookup_pc,
    output pred_taken, taken, resolved, redirect, redirect_pc, flush,
    output br_count, mispred_count
  );
endinterface

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table: DEPTH two-bit saturating counters indexed by the low
// PC bits. One combinational read port (prediction) and one update port. The
// read sees the stored value, so a same-index update in the same cycle is
// only visible from the next cycle on.
module branch_bht
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int PC_WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] rd_pc_i,
  output logic                rd_taken_o,
  input  logic                upd_en_i,
  input  logic [PC_WIDTH-1:0] upd_pc_i,
  input  logic                upd_taken_i
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       ctr_q [DEPTH];
  logic [1:0]       upd_ctr_d;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;

  // Index extraction, prediction read and next value of the updated entry.
  always_comb begin
    rd_idx     = rd_pc_i[IDX_W-1:0];
    upd_idx    = upd_pc_i[IDX_W-1:0];
    rd_taken_o = ctr_q[rd_idx][1];
    upd_ctr_d  = bht_next(ctr_q[upd_idx], upd_taken_i);
  end

  // Counter array: all entries to weakly not-taken on reset, one write per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= WEAK_NT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx] <= upd_ctr_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: stores ALU flags, evaluates the branch condition one
// cycle after issue, compares against the fetch prediction and produces a
// registered redirect/flush plus the corrected next PC. Also trains the BHT
// and keeps saturating resolve/mispredict statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int PC_WIDTH     = 8,
  parameter int OFFSET_WIDTH = 5,
  parameter int BHT_DEPTH    = 16,
  parameter int CNT_WIDTH    = 16
) (
  input logic                  clock,
  input logic                  reset,
  branch_resolve_unit_if.slave bus
);

  alu_flags_t           flags_q, flags_d;
  alu_flags_t           flags_in, flags_eff;
  logic                 cond;
  logic                 mispredict;
  logic [PC_WIDTH-1:0]  offset_ext;
  logic [PC_WIDTH-1:0]  next_pc;

  logic                 taken_q, taken_d;
  logic                 resolved_q, resolved_d;
  logic                 redirect_q, redirect_d;
  logic [PC_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
  logic [CNT_WIDTH-1:0] mispred_count_q, mispred_count_d;
  logic [SAT_W-1:0]     br_count_inc, mispred_count_inc;

  // Flag capture and bypass: a branch issued together with a flag write must
  // see the flags being written, not the stale stored set.
  always_comb begin
    flags_in  = '{z: bus.alu_zero, n: bus.alu_neg, c: bus.alu_carry, v: bus.alu_ovf};
    flags_eff = bus.flag_we ? flags_in : flags_q;
    flags_d   = flags_eff;
  end

  // Direction, mispredict and corrected target. Sign-extending cast keeps the
  // add modulo 2^PC_WIDTH, so targets wrap around the PC space.
  always_comb begin
    cond       = eval_cond(bus.br_cond, flags_eff);
    mispredict = cond != bus.br_pred_taken;
    offset_ext = PC_WIDTH'(signed'(bus.br_offset));
    next_pc    = cond ? bus.br_pc + offset_ext : bus.br_pc + PC_WIDTH'(1);
  end

  // Next state of the resolve outputs and statistics counters.
  always_comb begin
    taken_d           = taken_q;
    resolved_d        = 1'b0;
    redirect_d        = 1'b0;
    redirect_pc_d     = redirect_pc_q;
    br_count_d        = br_count_q;
    mispred_count_d   = mispred_count_q;
    br_count_inc      = sat_inc(SAT_W'(br_count_q), CNT_WIDTH);
    mispred_count_inc = sat_inc(SAT_W'(mispred_count_q), CNT_WIDTH);
    if (bus.br_valid) begin
      taken_d       = cond;
      resolved_d    = 1'b1;
      redirect_d    = mispredict;
      redirect_pc_d = next_pc;
      br_count_d    = br_count_inc[CNT_WIDTH-1:0];
      if (mispredict) mispred_count_d = mispred_count_inc[CNT_WIDTH-1:0];
    end
  end

  // State registers; reset also drops any resolution issued on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      flags_q         <= '0;
      taken_q         <= 1'b0;
      resolved_q      <= 1'b0;
      redirect_q      <= 1'b0;
      redirect_pc_q   <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      flags_q         <= flags_d;
      taken_q         <= taken_d;
      resolved_q      <= resolved_d;
      redirect_q      <= redirect_d;
      redirect_pc_q   <= redirect_pc_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  branch_bht #(
    .DEPTH    (BHT_DEPTH),
    .PC_WIDTH (PC_WIDTH)
  ) u_bht (
    .clock       (clock),
    .reset       (reset),
    .rd_pc_i     (bus.lookup_pc),
    .rd_taken_o  (bus.pred_taken),
    .upd_en_i    (bus.br_valid),
    .upd_pc_i    (bus.br_pc),
    .upd_taken_i (cond)
  );

  // Output drive; flush is the same pulse as redirect.
  always_comb begin
    bus.taken         = taken_q;
    bus.resolved      = resolved_q;
    bus.redirect      = redirect_q;
    bus.flush         = redirect_q;
    bus.redirect_pc   = redirect_pc_q;
    bus.br_count      = br_count_q;
    bus.mispred_count = mispred_count_q;
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios followed by random
// traffic, all checked against a behavioural model of the branch rules.
module tb_branch_resolve_unit;
  localparam int PCW   = 8;
  localparam int OFW   = 5;
  localparam int CW    = 16;
  localparam int DEPTH = 16;
  localparam int EW    = 3 + PCW + 2 * CW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  branch_resolve_unit_if #(.PC_WIDTH(PCW), .OFFSET_WIDTH(OFW), .CNT_WIDTH(CW)) bus ();

  branch_resolve_unit #(
    .PC_WIDTH(PCW), .OFFSET_WIDTH(OFW), .BHT_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  int m_z, m_n, m_c, m_v;
  int m_bht[DEPTH];
  int m_taken, m_rpc, m_brc, m_mis;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cond_val(input int cc, input int z, n, c, v);
    case (cc)
      0: return 0;
      1: return 1;
      2: return z;
      3: return (z == 0) ? 1 : 0;
      4: return (n != v) ? 1 : 0;
      5: return (n == v) ? 1 : 0;
      6: return (c == 0) ? 1 : 0;
      default: return c;
    endcase
  endfunction

  function automatic int wrap_pc(input int x);
    return ((x % (1 << PCW)) + (1 << PCW)) % (1 << PCW);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_flags(input int we, z, n, c, v);
    bus.flag_we   = 1'(we);
    bus.alu_zero  = 1'(z);
    bus.alu_neg   = 1'(n);
    bus.alu_carry = 1'(c);
    bus.alu_ovf   = 1'(v);
  endtask

  task automatic set_br(input int bv, cc, pc, off, pred);
    bus.br_valid      = 1'(bv);
    bus.br_cond       = 3'(cc);
    bus.br_pc         = PCW'(pc);
    bus.br_offset     = OFW'(off);
    bus.br_pred_taken = 1'(pred);
  endtask

  task automatic idle();
    set_flags(0, 0, 0, 0, 0);
    set_br(0, 0, 0, 0, 0);
  endtask

  // One clock: check the combinational prediction, advance the model with the
  // driven inputs, clock the DUT and compare the registered outputs.
  task automatic do_cycle();
    int z, n, c, v, cv, mis, idx, off, res, red;
    logic [EW-1:0] e;
    #1;
    check("pred_taken", 64'(bus.pred_taken), 64'(m_bht[int'(bus.lookup_pc) % DEPTH] >= 2));
    res = 0;
    red = 0;
    if (reset) begin
      m_z = 0; m_n = 0; m_c = 0; m_v = 0;
      for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
      m_taken = 0; m_rpc = 0; m_brc = 0; m_mis = 0;
    end else begin
      z = bus.flag_we ? int'(bus.alu_zero)  : m_z;
      n = bus.flag_we ? int'(bus.alu_neg)   : m_n;
      c = bus.flag_we ? int'(bus.alu_carry) : m_c;
      v = bus.flag_we ? int'(bus.alu_ovf)   : m_v;
      if (bus.br_valid) begin
        cv  = cond_val(int'(bus.br_cond), z, n, c, v);
        mis = (cv != int'(bus.br_pred_taken)) ? 1 : 0;
        off = int'(bus.br_offset) - (bus.br_offset[OFW-1] ? (1 << OFW) : 0);
        m_rpc = cv ? wrap_pc(int'(bus.br_pc) + off) : wrap_pc(int'(bus.br_pc) + 1);
        idx = int'(bus.br_pc) % DEPTH;
        if (cv) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
        else    m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
        if (m_brc < (1 << CW) - 1) m_brc++;
        if (mis && m_mis < (1 << CW) - 1) m_mis++;
        m_taken = cv;
        res = 1;
        red = mis;
      end
      if (bus.flag_we) begin
        m_z = z; m_n = n; m_c = c; m_v = v;
      end
    end
    exp_q.push_back({1'(m_taken), 1'(res), 1'(red), PCW'(m_rpc), CW'(m_brc), CW'(m_mis)});
    @(posedge clock);
    @(negedge clock);
    e = exp_q.pop_front();
    check("taken",         64'(bus.taken),         64'(e[EW-1]));
    check("resolved",      64'(bus.resolved),      64'(e[EW-2]));
    check("redirect",      64'(bus.redirect),      64'(e[EW-3]));
    check("flush",         64'(bus.flush),         64'(e[EW-3]));
    check("redirect_pc",   64'(bus.redirect_pc),   64'(e[2*CW +: PCW]));
    check("br_count",      64'(bus.br_count),      64'(e[CW +: CW]));
    check("mispred_count", 64'(bus.mispred_count), 64'(e[0 +: CW]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_z = 0; m_n = 0; m_c = 0; m_v = 0;
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    m_taken = 0; m_rpc = 0; m_brc = 0; m_mis = 0;
    reset = 1'b1;
    idle();
    bus.lookup_pc = '0;
    @(negedge clock);

    // Reset state: outputs zero and every BHT entry predicts not-taken.
    for (int i = 0; i < DEPTH; i++) begin
      bus.lookup_pc = PCW'(i);
      do_cycle();
    end
    reset = 1'b0;
    check("reset_br_count", 64'(bus.br_count), 64'd0);

    // Legacy NE: Z=0, NE taken while predicted not-taken.
    set_flags(1, 0, 0, 0, 0); set_br(0, 0, 0, 0, 0); do_cycle();
    set_flags(0, 0, 0, 0, 0); set_br(1, 3, 8'h10, 4, 0); do_cycle();
    check("ne_rpc_const",  64'(bus.redirect_pc),   64'h14);
    check("ne_mis_const",  64'(bus.mispred_count), 64'd1);

    // Bypass: flag write and EQ branch in the same cycle.
    set_flags(1, 1, 0, 0, 0); set_br(1, 2, 8'h20, -2, 1); do_cycle();
    check("bypass_redirect", 64'(bus.redirect), 64'd0);

    // Signed vs unsigned compares with N=1 V=0 C=1.
    set_flags(1, 0, 1, 1, 0); set_br(0, 0, 0, 0, 0); do_cycle();
    set_flags(0, 0, 0, 0, 0); set_br(1, 4, 8'h30, 5, 1); do_cycle();
    set_br(1, 6, 8'h30, 5, 1); do_cycle();
    check("ltu_taken", 64'(bus.taken), 64'd0);
    set_br(1, 7, 8'h30, 5, 0); do_cycle();
    check("geu_rpc_const", 64'(bus.redirect_pc), 64'h35);

    // PC wrap in both directions.
    set_br(1, 0, 8'hFF, 3, 1); do_cycle();
    check("wrap_up_const", 64'(bus.redirect_pc), 64'h00);
    set_br(1, 1, 8'h02, -4, 0); do_cycle();
    check("wrap_down_const", 64'(bus.redirect_pc), 64'hFE);

    // BHT saturation at index 3 with lookup on the same index (read-before-write).
    bus.lookup_pc = 8'h03;
    for (int i = 0; i < 4; i++) begin
      set_br(1, 1, 8'h03, 1, 0); do_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      set_br(1, 0, 8'h03, 1, 0); do_cycle();
    end
    set_br(0, 0, 0, 0, 0); do_cycle();

    // Random traffic, including back-to-back branches and same-index lookups.
    for (int i = 0; i < 400; i++) begin
      set_flags(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      set_br(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7),
             $urandom_range(0, 255), $urandom_range(0, 31), $urandom_range(0, 1));
      bus.lookup_pc = ($urandom_range(0, 1) == 1) ? bus.br_pc : PCW'($urandom_range(0, 255));
      do_cycle();
    end

    // Reset on an edge carrying a mispredicting branch: no pulse, all cleared.
    set_flags(0, 0, 0, 0, 0); set_br(1, 1, 8'h40, 3, 0);
    reset = 1'b1;
    do_cycle();
    check("rst_mid_redirect", 64'(bus.redirect), 64'd0);
    reset = 1'b0;
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      bus.lookup_pc = PCW'(i);
      do_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised successor to the single-gate zero/branch AND in the nRISC datapath. It holds a registered ALU flag set and evaluates eight branch conditions instead of only "not zero and branch". It resolves each branch one cycle after issue against the fetch-stage prediction and drives a registered redirect/flush to the PC logic. It also owns a 2-bit branch history table (BHT) and saturating statistics counters.

Parameters:
PC_WIDTH, 8, width of PC and of redirect target (instruction-addressed)
OFFSET_WIDTH, 5, width of signed two's-complement branch offset
BHT_DEPTH, 16, BHT entries; power of 2, index = low log2(BHT_DEPTH) PC bits
CNT_WIDTH, 16, width of statistics counters

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
flag_we  in  1  capture ALU flags this cycle
alu_zero  in  1  ALU Z
alu_neg  in  1  ALU N
alu_carry  in  1  ALU C (1 = no borrow on subtract)
alu_ovf  in  1  ALU V
br_valid  in  1  branch instruction present in resolve stage
br_cond  in  3  condition code
br_pc  in  PC_WIDTH  PC of the branch
br_offset  in  OFFSET_WIDTH  signed offset relative to br_pc
br_pred_taken  in  1  prediction made at fetch for this branch
lookup_pc  in  PC_WIDTH  fetch PC for prediction query
pred_taken  out  1  BHT prediction for lookup_pc (combinational)
taken  out  1  registered resolved direction, valid with resolved
resolved  out  1  one-cycle pulse, branch resolved
redirect  out  1  one-cycle pulse, mispredict, PC must load redirect_pc
redirect_pc  out  PC_WIDTH  correct next PC, valid with redirect
flush  out  1  equals redirect, kills younger instructions
br_count  out  CNT_WIDTH  branches resolved, saturating
mispred_count  out  CNT_WIDTH  mispredicts, saturating

Behaviour:
- Reset (synchronous, clock and reset as named above): flags Z/N/C/V = 0; taken, resolved, redirect, flush = 0; redirect_pc = 0; counters = 0; every BHT entry = 2'b01 (weakly not-taken). Reset takes priority over all inputs. An in-flight resolution is discarded and no pulse is emitted.
- Flag register: on flag_we, capture Z/N/C/V. Otherwise hold.
- Flag bypass: when br_valid and flag_we are high in the same cycle, the condition uses the incoming alu_* values, not the stored flags.
- Conditions: 000 NEVER = 0; 001 ALWAYS = 1; 010 EQ = Z; 011 NE = ~Z (legacy behaviour); 100 LT = N^V; 101 GE = ~(N^V); 110 LTU = ~C; 111 GEU = C.
- Resolution latency is 1 cycle. On the edge where br_valid=1, register taken=cond and resolved=1.
- On that edge, register redirect=flush=(cond != br_pred_taken).
- On that edge, register redirect_pc = cond ? br_pc + sext(br_offset) : br_pc + 1. The result wraps modulo 2^PC_WIDTH, e.g. PC 0xFF + 1 = 0x00.
- When br_valid=0, resolved/redirect/flush return to 0 next cycle. taken and redirect_pc hold their last value.
- Back-to-back br_valid on consecutive cycles is legal. Each branch produces its own pulse in the following cycle.
- BHT: on br_valid, entry[br_pc idx] increments if cond=1 and decrements if cond=0, saturating at 0 and 3.
- pred_taken = entry[lookup_pc idx][1].
- Same-index read and write in one cycle: pred_taken shows the pre-update value (read-before-write).
- Counters: br_count += 1 per br_valid; mispred_count += 1 per mispredict. Both hold at all-ones and never wrap.

Decomposition:
- Shared package: condition-code constants (COND_NEVER..COND_GEU), BHT reset constant WEAK_NT = 2'b01, counter-saturation helper function.
- One sub-module: branch_bht (BHT_DEPTH x 2-bit counters, one combinational read port, one write/update port, synchronous reset to WEAK_NT). Condition logic, flags, redirect and counters stay in the top.

Test Plan:
- Legacy NE: flag_we with alu_zero=0, then br_valid cond=011 pc=0x10 offset=+4 pred=0 -> next cycle taken=1, redirect=flush=1, redirect_pc=0x14, mispred_count=1.
- Bypass: same cycle flag_we alu_zero=1 and br_valid cond=010 pc=0x20 offset=-2 pred=1 -> taken=1, redirect=0, br_count=1.
- Signed vs unsigned: flags N=1 V=0 C=1; cond=100 -> taken=1; cond=110 -> taken=0; cond=111 pred=0 -> redirect_pc = pc+offset.
- Wrap: not-taken mispredict at pc=0xFF (pred=1) -> redirect_pc=0x00. Taken at pc=0x02 offset=-4 -> redirect_pc=0xFE.
- BHT saturation: four taken resolutions at pc=0x03 -> pred_taken for lookup_pc=0x03 goes 0,1,1,1. Then two not-taken -> entry 3->2->1, pred_taken=0. A same-cycle lookup during update shows the old value.
- Reset mid-operation: assert reset on the edge with br_valid and mispredict -> no redirect pulse, counters=0, all BHT entries read pred_taken=0.
